// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite encodings and the LSU bridge FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Privileged, non-bufferable, non-cacheable; bit 0 selects data vs opcode.
    localparam logic [3:0] HPROT_DATA   = 4'b0011;
    localparam logic [3:0] HPROT_OPCODE = 4'b0010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ERR1 = 2'd2,
        LERR = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/ahb_be_decode.sv
// Byte-enable to HSIZE / lane offset / legality decode.
// Latency: purely combinational.
// Backpressure: none.
// Ports: be (lane enables in), size (HSIZE out), offset (low address bits out),
//        legal (1 = be is a naturally aligned byte/half/word/dword group).
module ahb_be_decode
    import ahb3lite_pkg::*;
#(
    parameter  int BE_WIDTH  = 4,
    localparam int OFF_WIDTH = $clog2(BE_WIDTH)
) (
    input  logic [BE_WIDTH-1:0]  be,
    output logic [2:0]           size,
    output logic [OFF_WIDTH-1:0] offset,
    output logic                 legal
);

    // The candidate patterns are mutually exclusive, so at most one branch hits.
    always_comb begin
        size   = HSIZE_BYTE;
        offset = '0;
        legal  = 1'b0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be == (BE_WIDTH'(1) << i)) begin
                legal  = 1'b1;
                size   = HSIZE_BYTE;
                offset = OFF_WIDTH'(i);
            end
        end
        for (int i = 0; i < BE_WIDTH; i += 2) begin
            if (be == (BE_WIDTH'(2'b11) << i)) begin
                legal  = 1'b1;
                size   = HSIZE_HALF;
                offset = OFF_WIDTH'(i);
            end
        end
        for (int i = 0; i < BE_WIDTH; i += 4) begin
            if (be == (BE_WIDTH'(4'hF) << i)) begin
                legal  = 1'b1;
                size   = HSIZE_WORD;
                offset = OFF_WIDTH'(i);
            end
        end
        if (BE_WIDTH == 8 && be == '1) begin
            legal  = 1'b1;
            size   = HSIZE_DWORD;
            offset = '0;
        end
    end

endmodule

// File: rtl/ahb3lite_lsu_bridge.sv
// Core load/store request port to AHB3-Lite master bridge, single transfers only.
// Latency: address phase in the grant cycle; response at data-phase end (+1 cycle if REG_RSP).
// Backpressure: gnt_o follows HREADY_i and is withheld during the second error cycle.
// Ports: HCLK/HRESET; core side req/gnt/addr/we/be/wdata -> rvalid/rdata/err;
//        AHB side H*_o address/control/write data, HRDATA_i/HREADY_i/HRESP_i.
module ahb3lite_lsu_bridge
    import ahb3lite_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int IS_INSTR   = 0,
    parameter  int REG_RSP    = 0,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    // core side
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    // AHB side
    output logic [ADDR_WIDTH-1:0] HADDR_o,
    output logic [1:0]            HTRANS_o,
    output logic                  HWRITE_o,
    output logic [2:0]            HSIZE_o,
    output logic [2:0]            HBURST_o,
    output logic [3:0]            HPROT_o,
    output logic                  HMASTLOCK_o,
    output logic [DATA_WIDTH-1:0] HWDATA_o,
    input  logic [DATA_WIDTH-1:0] HRDATA_i,
    input  logic                  HREADY_i,
    input  logic                  HRESP_i
);

    localparam int OFF_WIDTH = $clog2(BE_WIDTH);

    lsu_state_t state, state_nxt;

    logic [2:0]           dec_size;
    logic [OFF_WIDTH-1:0] dec_off;
    logic                 dec_legal;

    ahb_be_decode #(.BE_WIDTH(BE_WIDTH)) u_be_decode (
        .be     (be_i),
        .size   (dec_size),
        .offset (dec_off),
        .legal  (dec_legal)
    );

    // Grant is masked by HRESET so the async reset silences the core side at once.
    logic grant;
    logic issue;
    assign grant = req_i & HREADY_i & (state != ERR1) & ~HRESET;
    assign issue = grant & dec_legal;
    assign gnt_o = grant;

    logic [ADDR_WIDTH-1:0] issue_addr;
    always_comb begin
        issue_addr                = addr_i;
        issue_addr[OFF_WIDTH-1:0] = dec_off;
    end

    // Last issued address-phase values; keep the bus quiet between transfers
    // and provide the write data for the following data phase.
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic [DATA_WIDTH-1:0] hwdata_q;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= HSIZE_BYTE;
            hwdata_q <= '0;
        end else if (issue) begin
            haddr_q  <= issue_addr;
            hwrite_q <= we_i;
            hsize_q  <= dec_size;
            hwdata_q <= wdata_i;
        end
    end

    assign HADDR_o     = issue ? issue_addr : haddr_q;
    assign HWRITE_o    = issue ? we_i : hwrite_q;
    assign HSIZE_o     = issue ? dec_size : hsize_q;
    assign HTRANS_o    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWDATA_o    = hwdata_q;
    assign HBURST_o    = HBURST_SINGLE;
    assign HMASTLOCK_o = 1'b0;
    assign HPROT_o     = (IS_INSTR != 0) ? HPROT_OPCODE : HPROT_DATA;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    logic                  rsp_vld;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_dat;

    always_comb begin
        state_nxt = state;
        rsp_vld   = 1'b0;
        rsp_err   = 1'b0;
        rsp_dat   = '0;
        case (state)
            DATA: begin
                if (HREADY_i) begin
                    rsp_vld   = 1'b1;
                    rsp_err   = HRESP_i;
                    rsp_dat   = HRESP_i ? '0 : HRDATA_i;
                    state_nxt = IDLE;
                end else if (HRESP_i) begin
                    state_nxt = ERR1;
                end
            end
            ERR1: begin
                if (HREADY_i) begin
                    rsp_vld   = 1'b1;
                    rsp_err   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            LERR: begin
                rsp_vld   = 1'b1;
                rsp_err   = 1'b1;
                state_nxt = IDLE;
            end
            default: ;
        endcase
        // A grant can only coincide with a finishing (or absent) data phase,
        // so it always decides the following state.
        if (grant) state_nxt = dec_legal ? DATA : LERR;
    end

    if (REG_RSP != 0) begin : g_rsp_reg
        logic                  rvalid_q;
        logic                  err_q;
        logic [DATA_WIDTH-1:0] rdata_q;
        always_ff @(posedge HCLK or posedge HRESET) begin
            if (HRESET) begin
                rvalid_q <= 1'b0;
                err_q    <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rsp_vld;
                err_q    <= rsp_err;
                rdata_q  <= rsp_dat;
            end
        end
        assign rvalid_o = rvalid_q;
        assign err_o    = err_q;
        assign rdata_o  = rdata_q;
    end else begin : g_rsp_comb
        assign rvalid_o = rsp_vld;
        assign err_o    = rsp_err;
        assign rdata_o  = rsp_dat;
    end

endmodule

// File: tb/tb_ahb3lite_lsu_bridge.sv
// Testbench for ahb3lite_lsu_bridge: 32-bit combinational-response data port
// against a protocol-level slave/core model, plus a 64-bit registered-response
// opcode port for wide decode and response timing.
// Inputs are driven 1ns after the rising edge; outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_ahb3lite_lsu_bridge;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;
    logic HRESET;

    // 32-bit, REG_RSP=0, data port
    logic        a_req, a_gnt, a_we, a_rvalid, a_err, a_hwrite, a_hmastlock, a_hready, a_hresp;
    logic [31:0] a_addr, a_wdata, a_rdata, a_haddr, a_hwdata, a_hrdata;
    logic [3:0]  a_be, a_hprot;
    logic [1:0]  a_htrans;
    logic [2:0]  a_hsize, a_hburst;

    // 64-bit, REG_RSP=1, opcode port
    logic        b_req, b_gnt, b_we, b_rvalid, b_err, b_hwrite, b_hmastlock, b_hready, b_hresp;
    logic [31:0] b_addr, b_haddr;
    logic [63:0] b_wdata, b_rdata, b_hwdata, b_hrdata;
    logic [7:0]  b_be;
    logic [3:0]  b_hprot;
    logic [1:0]  b_htrans;
    logic [2:0]  b_hsize, b_hburst;

    ahb3lite_lsu_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .IS_INSTR(0), .REG_RSP(0)) u_dut_a (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr), .we_i(a_we), .be_i(a_be), .wdata_i(a_wdata),
        .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err),
        .HADDR_o(a_haddr), .HTRANS_o(a_htrans), .HWRITE_o(a_hwrite), .HSIZE_o(a_hsize),
        .HBURST_o(a_hburst), .HPROT_o(a_hprot), .HMASTLOCK_o(a_hmastlock), .HWDATA_o(a_hwdata),
        .HRDATA_i(a_hrdata), .HREADY_i(a_hready), .HRESP_i(a_hresp)
    );

    ahb3lite_lsu_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .IS_INSTR(1), .REG_RSP(1)) u_dut_b (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_i(b_req), .gnt_o(b_gnt), .addr_i(b_addr), .we_i(b_we), .be_i(b_be), .wdata_i(b_wdata),
        .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err),
        .HADDR_o(b_haddr), .HTRANS_o(b_htrans), .HWRITE_o(b_hwrite), .HSIZE_o(b_hsize),
        .HBURST_o(b_hburst), .HPROT_o(b_hprot), .HMASTLOCK_o(b_hmastlock), .HWDATA_o(b_hwdata),
        .HRDATA_i(b_hrdata), .HREADY_i(b_hready), .HRESP_i(b_hresp)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane-enable rule: one lane, an aligned pair, an aligned quad, or all 8 lanes.
    function automatic void ref_decode(input int lanes, input logic [7:0] be,
                                       output bit legal, output logic [2:0] size, output int off);
        int n, lo;
        n = $countones(be);
        lo = 0; legal = 0; size = 3'd0; off = 0;
        for (int i = lanes - 1; i >= 0; i--) if (be[i]) lo = i;
        if (n == 1) begin
            legal = 1; size = 3'd0; off = lo;
        end else if (n == 2 && lo % 2 == 0 && (be >> lo) == 8'h03) begin
            legal = 1; size = 3'd1; off = lo;
        end else if (n == 4 && lo % 4 == 0 && (be >> lo) == 8'h0F) begin
            legal = 1; size = 3'd2; off = lo;
        end else if (n == 8 && lanes == 8) begin
            legal = 1; size = 3'd3; off = 0;
        end
    endfunction

    // Slave / transaction model state for DUT A
    bit          sl_busy, sl_err, sl_ephase, sl_write, lerr_pend, use_force_rdata;
    int          sl_wait;
    logic [31:0] sl_rdata, sl_wdata, force_rdata;
    int          force_wait = -1;
    int          force_err  = -1;
    int          n_gnt = 0;
    int          n_rsp = 0;

    logic        s_gnt, s_rvalid, s_err;
    logic [1:0]  s_htrans;
    logic [2:0]  s_hsize;
    logic [31:0] s_haddr, s_rdata;

    // One bus cycle on DUT A: slave drives its handshake, outputs are checked
    // against the protocol model, then the model advances.
    task automatic a_cycle();
        bit          err2, gnt_e, legal, issue_e, fin;
        logic [2:0]  size;
        int          off;
        a_hresp  = 1'b0;
        a_hready = 1'b1;
        a_hrdata = $urandom;
        if (sl_busy) begin
            if (sl_wait > 0) a_hready = 1'b0;
            else if (sl_err && !sl_ephase) begin a_hready = 1'b0; a_hresp = 1'b1; end
            else if (sl_err) a_hresp = 1'b1;
            else a_hrdata = sl_rdata;
        end
        @(negedge HCLK);
        err2    = sl_busy && sl_err && sl_ephase;
        gnt_e   = a_req && a_hready && !err2;
        ref_decode(4, {4'b0, a_be}, legal, size, off);
        issue_e = gnt_e && legal;
        fin     = sl_busy && a_hready;
        s_gnt = a_gnt; s_htrans = a_htrans; s_haddr = a_haddr; s_hsize = a_hsize;
        s_rvalid = a_rvalid; s_err = a_err; s_rdata = a_rdata;
        chk("gnt", a_gnt, gnt_e);
        chk("htrans", a_htrans, issue_e ? 2'b10 : 2'b00);
        if (issue_e) begin
            chk("haddr", a_haddr, {a_addr[31:2], 2'(off)});
            chk("hwrite", a_hwrite, a_we);
            chk("hsize", a_hsize, size);
        end
        if (sl_busy && sl_write) chk("hwdata", a_hwdata, sl_wdata);
        if (fin) begin
            chk("rvalid", a_rvalid, 1'b1);
            chk("err", a_err, sl_err);
            chk("rdata", a_rdata, sl_err ? 32'h0 : sl_rdata);
        end else if (lerr_pend) begin
            chk("lerr_rvalid", a_rvalid, 1'b1);
            chk("lerr_err", a_err, 1'b1);
            chk("lerr_rdata", a_rdata, 32'h0);
        end else begin
            chk("idle_rvalid", a_rvalid, 1'b0);
            chk("idle_rdata", a_rdata, 32'h0);
        end
        if (a_rvalid) n_rsp++;
        if (gnt_e) n_gnt++;
        lerr_pend = gnt_e && !legal;
        if (sl_busy) begin
            if (sl_wait > 0) sl_wait--;
            else if (sl_err && !sl_ephase) sl_ephase = 1;
            else sl_busy = 0;
        end
        if (issue_e) begin
            sl_busy   = 1;
            sl_wait   = (force_wait >= 0) ? force_wait : $urandom_range(0, 2);
            sl_err    = (force_err >= 0) ? (force_err != 0) : ($urandom_range(0, 4) == 0);
            sl_ephase = 0;
            sl_rdata  = use_force_rdata ? force_rdata : $urandom;
            sl_write  = a_we;
            sl_wdata  = a_wdata;
        end
        @(posedge HCLK);
        #1;
    endtask

    typedef struct {
        logic [3:0]  be;
        logic [31:0] addr;
        logic        we;
        logic [31:0] rdata;
        bit          legal;
        logic [2:0]  size;
        logic [31:0] haddr;
    } avec_t;

    typedef struct {
        logic [7:0]  be;
        logic [31:0] addr;
        bit          legal;
        logic [2:0]  size;
        logic [31:0] haddr;
    } bvec_t;

    avec_t av[10];
    bvec_t bv[6];
    int    stalls;
    bit    got;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        av[0] = '{4'hF, 32'h100, 1'b0, 32'hDEADBEEF, 1, 3'b010, 32'h100};
        av[1] = '{4'h1, 32'h103, 1'b0, 32'h01020304, 1, 3'b000, 32'h100};
        av[2] = '{4'h2, 32'h100, 1'b1, 32'h0,        1, 3'b000, 32'h101};
        av[3] = '{4'h8, 32'h110, 1'b0, 32'hA5A5A5A5, 1, 3'b000, 32'h113};
        av[4] = '{4'h3, 32'h201, 1'b0, 32'h12345678, 1, 3'b001, 32'h200};
        av[5] = '{4'hC, 32'h200, 1'b1, 32'h0,        1, 3'b001, 32'h202};
        av[6] = '{4'h5, 32'h400, 1'b0, 32'h0,        0, 3'b000, 32'h0};
        av[7] = '{4'h0, 32'h404, 1'b0, 32'h0,        0, 3'b000, 32'h0};
        av[8] = '{4'h6, 32'h408, 1'b1, 32'h0,        0, 3'b000, 32'h0};
        av[9] = '{4'h7, 32'h40C, 1'b0, 32'h0,        0, 3'b000, 32'h0};

        bv[0] = '{8'hF0, 32'h508, 1, 3'b010, 32'h50C};
        bv[1] = '{8'hFF, 32'h50F, 1, 3'b011, 32'h508};
        bv[2] = '{8'h0C, 32'h500, 1, 3'b001, 32'h502};
        bv[3] = '{8'h80, 32'h500, 1, 3'b000, 32'h507};
        bv[4] = '{8'h05, 32'h400, 0, 3'b000, 32'h0};
        bv[5] = '{8'h3C, 32'h400, 0, 3'b000, 32'h0};

        HRESET = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h123; a_be = 4'hF; a_wdata = 32'h55AA55AA;
        a_hready = 1'b1; a_hresp = 1'b0; a_hrdata = 32'hFFFFFFFF;
        b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_be = 8'h0; b_wdata = 64'h0;
        b_hready = 1'b1; b_hresp = 1'b0; b_hrdata = 64'h0123456789ABCDEF;
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_gnt", a_gnt, 1'b0);
        chk("rst_htrans", a_htrans, 2'b00);
        chk("rst_rvalid", a_rvalid, 1'b0);
        chk("rst_rdata", a_rdata, 32'h0);
        chk("rst_haddr", a_haddr, 32'h0);
        chk("rst_hwdata", a_hwdata, 32'h0);
        chk("rst_hsize", a_hsize, 3'b000);
        chk("rst_hwrite", a_hwrite, 1'b0);
        chk("hburst", a_hburst, 3'b000);
        chk("hmastlock", a_hmastlock, 1'b0);
        chk("hprot_data", a_hprot, 4'b0011);
        HRESET = 1'b0;
        a_req = 1'b0;

        // Decode table, one isolated request each, zero wait, OKAY response
        force_wait = 0; force_err = 0; use_force_rdata = 1;
        for (int i = 0; i < 10; i++) begin
            a_req = 1'b1; a_be = av[i].be; a_addr = av[i].addr; a_we = av[i].we;
            a_wdata = $urandom; force_rdata = av[i].rdata;
            a_cycle();
            chk($sformatf("tbl%0d_gnt", i), s_gnt, 1'b1);
            chk($sformatf("tbl%0d_htrans", i), s_htrans, av[i].legal ? 2'b10 : 2'b00);
            if (av[i].legal) begin
                chk($sformatf("tbl%0d_haddr", i), s_haddr, av[i].haddr);
                chk($sformatf("tbl%0d_hsize", i), s_hsize, av[i].size);
            end
            a_req = 1'b0;
            a_cycle();
            chk($sformatf("tbl%0d_rvalid", i), s_rvalid, 1'b1);
            chk($sformatf("tbl%0d_err", i), s_err, !av[i].legal);
            chk($sformatf("tbl%0d_rdata", i), s_rdata, av[i].legal ? av[i].rdata : 32'h0);
        end
        use_force_rdata = 0;

        // Back-to-back halfword writes, two wait states on the first
        force_wait = 2;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h200; a_be = 4'h3; a_wdata = 32'h11112222;
        a_cycle();
        chk("b2b_gnt1", s_gnt, 1'b1);
        chk("b2b_haddr1", s_haddr, 32'h200);
        chk("b2b_hsize1", s_hsize, 3'b001);
        force_wait = 0;
        a_addr = 32'h206; a_be = 4'hC; a_wdata = 32'h33334444;
        got = 0; stalls = 0;
        for (int k = 0; k < 6 && !got; k++) begin
            a_cycle();
            if (s_gnt) got = 1;
            else stalls++;
        end
        chk("b2b_gnt2", got, 1'b1);
        chk("b2b_stalls", stalls, 2);
        chk("b2b_haddr2", s_haddr, 32'h206);
        chk("b2b_hsize2", s_hsize, 3'b001);
        chk("b2b_rvalid1", s_rvalid, 1'b1);
        a_req = 1'b0;
        a_cycle();
        chk("b2b_rvalid2", s_rvalid, 1'b1);

        // Two-cycle ERROR response with a request waiting behind it
        force_err = 1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h300; a_be = 4'hF;
        a_cycle();
        chk("err_gnt", s_gnt, 1'b1);
        force_err = 0;
        a_addr = 32'h304;
        a_cycle();
        chk("err1_gnt", s_gnt, 1'b0);
        a_cycle();
        chk("err2_gnt", s_gnt, 1'b0);
        chk("err2_htrans", s_htrans, 2'b00);
        chk("err2_rvalid", s_rvalid, 1'b1);
        chk("err2_err", s_err, 1'b1);
        chk("err2_rdata", s_rdata, 32'h0);
        a_cycle();
        chk("err_next_gnt", s_gnt, 1'b1);
        chk("err_next_haddr", s_haddr, 32'h304);
        a_req = 1'b0;
        a_cycle();
        chk("err_next_ok", s_err, 1'b0);

        // Reset in the middle of a wait-stated read
        force_wait = 3;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h600; a_be = 4'hF;
        a_cycle();
        a_req = 1'b0;
        a_cycle();
        a_req = 1'b1; a_hready = 1'b1; HRESET = 1'b1;
        #1;
        chk("mrst_gnt", a_gnt, 1'b0);
        chk("mrst_htrans", a_htrans, 2'b00);
        chk("mrst_rvalid", a_rvalid, 1'b0);
        chk("mrst_err", a_err, 1'b0);
        chk("mrst_rdata", a_rdata, 32'h0);
        chk("mrst_hwdata", a_hwdata, 32'h0);
        chk("mrst_haddr", a_haddr, 32'h0);
        chk("mrst_hwrite", a_hwrite, 1'b0);
        chk("mrst_hsize", a_hsize, 3'b000);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        sl_busy = 0; lerr_pend = 0; n_gnt = 0; n_rsp = 0;
        force_wait = 0;
        a_req = 1'b1; a_addr = 32'h700; a_be = 4'hF;
        a_cycle();
        chk("post_rst_gnt", s_gnt, 1'b1);
        a_req = 1'b0;
        repeat (4) a_cycle();

        // Randomized traffic against the model
        force_wait = -1; force_err = -1;
        for (int c = 0; c < 600; c++) begin
            a_req = ($urandom_range(0, 9) < 7);
            a_we = 1'($urandom); a_addr = $urandom; a_wdata = $urandom;
            case ($urandom_range(0, 3))
                0: a_be = 4'hF;
                1: a_be = 4'h3 << (2 * $urandom_range(0, 1));
                2: a_be = 4'h1 << $urandom_range(0, 3);
                default: a_be = 4'($urandom);
            endcase
            a_cycle();
        end
        a_req = 1'b0;
        repeat (8) a_cycle();
        chk("rsp_count", n_rsp, n_gnt);

        // 64-bit opcode port with registered response
        chk("hprot_opcode", b_hprot, 4'b0010);
        for (int i = 0; i < 6; i++) begin
            b_req = 1'b1; b_be = bv[i].be; b_addr = bv[i].addr;
            @(negedge HCLK);
            chk($sformatf("b%0d_gnt", i), b_gnt, 1'b1);
            chk($sformatf("b%0d_htrans", i), b_htrans, bv[i].legal ? 2'b10 : 2'b00);
            if (bv[i].legal) begin
                chk($sformatf("b%0d_haddr", i), b_haddr, bv[i].haddr);
                chk($sformatf("b%0d_hsize", i), b_hsize, bv[i].size);
            end
            @(posedge HCLK);
            #1;
            b_req = 1'b0;
            @(negedge HCLK);
            chk($sformatf("b%0d_rvalid_early", i), b_rvalid, 1'b0);
            @(negedge HCLK);
            chk($sformatf("b%0d_rvalid", i), b_rvalid, 1'b1);
            chk($sformatf("b%0d_err", i), b_err, !bv[i].legal);
            chk($sformatf("b%0d_rdata", i), b_rdata, bv[i].legal ? 64'h0123456789ABCDEF : 64'h0);
            @(negedge HCLK);
            chk($sformatf("b%0d_rvalid_after", i), b_rvalid, 1'b0);
            @(posedge HCLK);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb3lite_lsu_bridge.md
AHB3LITE_LSU_BRIDGE -- requirements
Module: ahb3lite_lsu_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bus data width; legal values 32 or 64; BE_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter IS_INSTR, default 0: 1 = opcode-fetch port, 0 = data port.
REQ-004 SHALL have parameter REG_RSP, default 0: 1 = registered response, 0 = combinational response.
REQ-005 HCLK  in  1  single clock; everything on rising edge.
REQ-006 HRESET  in  1  asynchronous, active-high reset.
REQ-007 Core side: req_i in 1; gnt_o out 1; addr_i in ADDR_WIDTH; we_i in 1; be_i in BE_WIDTH; wdata_i in DATA_WIDTH; rvalid_o out 1; rdata_o out DATA_WIDTH; err_o out 1 (error response, valid with rvalid_o).
REQ-008 AHB side: HADDR_o out ADDR_WIDTH; HTRANS_o out 2; HWRITE_o out 1; HSIZE_o out 3; HBURST_o out 3; HPROT_o out 4; HMASTLOCK_o out 1; HWDATA_o out DATA_WIDTH; HRDATA_i in DATA_WIDTH; HREADY_i in 1; HRESP_i in 1.

Function
REQ-009 HBURST_o SHALL be SINGLE (000) and HMASTLOCK_o SHALL be 0.
REQ-010 HPROT_o SHALL be 4'b0011 when IS_INSTR=0, and 4'b0010 when IS_INSTR=1.
REQ-011 be_i SHALL decode to size and offset: a single set bit gives byte size at that lane; an aligned pair gives halfword; an aligned 4-lane group gives word; all lanes set gives dword (64-bit only).
REQ-012 HADDR_o SHALL equal addr_i with its low log2(BE_WIDTH) bits replaced by the decoded lane offset.
REQ-013 Any other be_i pattern, including zero, SHALL be illegal.
REQ-014 FSM states SHALL be IDLE, DATA, ERR1, LERR.
REQ-015 gnt_o SHALL be combinational: req_i and HREADY_i and state not ERR1.
REQ-016 On gnt_o with legal be_i: HTRANS_o = NONSEQ in the same cycle, and write, wdata and lane info SHALL be captured for the data phase.
REQ-017 Any cycle without an issuing grant SHALL drive HTRANS_o = IDLE.
REQ-018 Data phase and next address phase SHALL overlap, giving back-to-back transfers, one per HREADY_i cycle.
REQ-019 HWDATA_o SHALL hold the captured write data for the whole data phase and be stable while HREADY_i is low.
REQ-020 Data phase completion (HREADY_i=1, HRESP_i=0) SHALL assert rvalid_o with rdata_o = HRDATA_i (full bus word, unshifted) and err_o=0.
REQ-021 When REG_RSP=0 the completion response SHALL appear in the same cycle; when REG_RSP=1 it SHALL appear one cycle later.
REQ-022 HRESP_i=1 with HREADY_i=0 during a data phase SHALL move to ERR1; in ERR1 gnt_o=0 and HTRANS_o=IDLE, cancelling any pending address.
REQ-023 In ERR1, HRESP_i=1 with HREADY_i=1 SHALL produce rvalid_o=1, err_o=1, rdata_o=0, then return to IDLE.
REQ-024 A grant with illegal be_i SHALL issue no bus transfer and enter LERR; in LERR it SHALL produce rvalid_o=1 and err_o=1, following REG_RSP timing.
REQ-025 rvalid_o SHALL pulse exactly once per grant, in grant order; at most one transfer SHALL be outstanding beyond the address phase.
REQ-026 Wait states (HREADY_i=0, HRESP_i=0) SHALL hold state, HWDATA_o and the pending address outputs unchanged.
REQ-027 rdata_o SHALL read 0 whenever rvalid_o=0.

Reset
REQ-028 HRESET SHALL force: state IDLE, HTRANS_o IDLE, gnt_o 0, rvalid_o 0, err_o 0, rdata_o 0, HWDATA_o 0, HADDR_o 0, HWRITE_o 0, HSIZE_o 0.
REQ-029 Reset mid-transfer SHALL discard the outstanding response and produce no rvalid_o after release.
REQ-030 The first grant SHALL be possible in the first cycle after reset deassertion.

Structure
REQ-031 Package ahb3lite_pkg SHALL hold the HTRANS, HSIZE, HBURST and HPROT encodings and the FSM state typedef.
REQ-032 The be_i to size/offset/legal decode SHALL be the sub-module ahb_be_decode, parametrised by BE_WIDTH and purely combinational.

Verification
REQ-033 Read, DATA_WIDTH=32, REG_RSP=0, addr 0x100, be 1111, HRDATA 0xDEADBEEF, zero wait -> HTRANS NONSEQ, HSIZE 010 in cycle 0; rvalid with 0xDEADBEEF in cycle 1.
REQ-034 Back-to-back writes to 0x200 (be 0011) and 0x206 (be 1100), HREADY with 2 wait states on the first -> HSIZE 001 for both, HADDR 0x200 then 0x206, HWDATA stable 3 cycles, two rvalid pulses in order.
REQ-035 Read at 0x300, slave two-cycle ERROR -> ERR1 drives HTRANS IDLE with pending req not granted; then rvalid=1, err=1, rdata=0; next request proceeds normally.
REQ-036 be 0101 at 0x400 -> gnt=1, no NONSEQ on bus; rvalid=1, err=1 next cycle (REG_RSP=1: one cycle later).
REQ-037 DATA_WIDTH=64, be 0xF0 at 0x508 -> HADDR 0x50C, HSIZE 010; be 0xFF -> HSIZE 011.
REQ-038 HRESET asserted during a wait-stated read -> all outputs at reset values immediately; no rvalid after release.
